// File: rtl/io_input_ctrl_pkg.sv
// Shared types and field positions for the switch input controller.
// Used by io_input_ctrl, its interface and the testbench.

package io_ctrl_pkg;

  localparam int SW_W   = 10;
  localparam int OPER_W = 5;

  localparam int OP0_HI = 9;
  localparam int OP0_LO = 5;
  localparam int OP1_HI = 4;
  localparam int OP1_LO = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } io_state_e;

endpackage

// File: rtl/io_input_ctrl_if.sv
// Switch/CPU-side signal bundle for io_input_ctrl.
// master = board/CPU side, slave = the controller.

interface io_input_ctrl_if
  import io_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);

  logic [SW_W-1:0]   sw;
  logic              cpu_rd;
  logic [DATA_W-1:0] in_port0;
  logic [DATA_W-1:0] in_port1;
  logic              data_valid;
  logic [CNT_W-1:0]  change_cnt;
  logic              overrun;

  modport master (
    output sw,
    output cpu_rd,
    input  in_port0,
    input  in_port1,
    input  data_valid,
    input  change_cnt,
    input  overrun
  );

  modport slave (
    input  sw,
    input  cpu_rd,
    output in_port0,
    output in_port1,
    output data_valid,
    output change_cnt,
    output overrun
  );

endinterface

// File: rtl/io_input_ctrl_sw_sync.sv
// Two-flop synchroniser for asynchronous switch levels.
// q is the second-flop output; both stages clear on reset.

module sw_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/io_input_ctrl.sv
// Debounces the board switches and commits stable values into two CPU input ports.
// Optional macro IO_OVERRUN_EN keeps the sticky overrun flag; otherwise overrun is tied low.
//
// state  | meaning
// IDLE   | synchronised switches match the committed value
// SETTLE | candidate differs from committed value, counting stable cycles
// COMMIT | one cycle: publish candidate, bump change_cnt, raise data_valid

module io_input_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_W          = 32,
  parameter int CNT_W           = 8
) (
  input logic            clk,
  input logic            reset,
  io_input_ctrl_if.slave io
);

  // Settle timer counts down from DEBOUNCE_CYCLES-1; terminal count is zero.
  localparam int TMR_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DEBOUNCE_CYCLES - 1);

  io_state_e         state;
  io_state_e         state_nxt;
  logic [SW_W-1:0]   sync;
  logic [SW_W-1:0]   stable;
  logic [SW_W-1:0]   candidate;
  logic [TMR_W-1:0]  tmr;
  logic              cand_load;
  logic              tmr_dec;
  logic              commit;
  logic [OPER_W-1:0] op0;
  logic [OPER_W-1:0] op1;
  logic [DATA_W-1:0] in_port0_q;
  logic [DATA_W-1:0] in_port1_q;
  logic [CNT_W-1:0]  change_cnt_q;
  logic              data_valid_q;

  sw_sync #(.W(SW_W)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (io.sw),
    .q     (sync)
  );

  assign op0 = candidate[OP0_HI:OP0_LO];
  assign op1 = candidate[OP1_HI:OP1_LO];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sync != stable) state_nxt = SETTLE;
      end
      SETTLE: begin
        // A bounce back to the committed value abandons the settle quietly.
        if (sync == stable)         state_nxt = IDLE;
        else if (sync != candidate) state_nxt = SETTLE;
        else if (tmr == '0)         state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    cand_load = 1'b0;
    tmr_dec   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        cand_load = (sync != stable);
      end
      SETTLE: begin
        if (sync != stable) begin
          if (sync != candidate) cand_load = 1'b1;
          else if (tmr != '0)    tmr_dec   = 1'b1;
        end
      end
      COMMIT: begin
        commit = 1'b1;
      end
      default: begin
        commit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      candidate <= '0;
      tmr       <= '0;
    end else if (cand_load) begin
      candidate <= sync;
      tmr       <= TMR_LOAD;
    end else if (tmr_dec) begin
      tmr       <= tmr - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable       <= '0;
      in_port0_q   <= '0;
      in_port1_q   <= '0;
      change_cnt_q <= '0;
    end else if (commit) begin
      stable       <= candidate;
      in_port0_q   <= DATA_W'(op0);
      in_port1_q   <= DATA_W'(op1);
      change_cnt_q <= change_cnt_q + CNT_W'(1);
    end
  end

  // A commit outranks a coincident acknowledge so fresh data is never dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_valid_q <= 1'b0;
    end else if (commit) begin
      data_valid_q <= 1'b1;
    end else if (io.cpu_rd) begin
      data_valid_q <= 1'b0;
    end
  end

`ifdef IO_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (commit && data_valid_q) begin
      overrun_q <= 1'b1;
    end else if (io.cpu_rd) begin
      overrun_q <= 1'b0;
    end
  end

  assign io.overrun = overrun_q;
`else
  assign io.overrun = 1'b0;
`endif

  assign io.in_port0   = in_port0_q;
  assign io.in_port1   = in_port1_q;
  assign io.data_valid = data_valid_q;
  assign io.change_cnt = change_cnt_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed bench for io_input_ctrl: reset, step, bounce, glitch, overrun and mid-settle reset.
// A switch value driven just after edge E is first sampled at E+1 and published at edge E+20.

module tb_io_input_ctrl;
  import io_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  io_input_ctrl_if #(.DATA_W(32), .CNT_W(8)) bus ();

  io_input_ctrl #(
    .DEBOUNCE_CYCLES (16),
    .DATA_W          (32),
    .CNT_W           (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

`ifdef IO_OVERRUN_EN
  localparam logic [31:0] OVR = 32'd1;
`else
  localparam logic [31:0] OVR = 32'd0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_pulse();
    bus.cpu_rd = 1'b1;
    step(1);
    bus.cpu_rd = 1'b0;
  endtask

  logic seen_dv;

  initial begin
    reset      = 1'b0;
    bus.sw     = '0;
    bus.cpu_rd = 1'b0;
    #1;
    chk("rst_dv",  32'(bus.data_valid), 32'd0);
    chk("rst_cnt", 32'(bus.change_cnt), 32'd0);
    step(3);
    reset = 1'b1;

    // Quiet switches: nothing ever commits.
    seen_dv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      seen_dv = seen_dv | bus.data_valid;
    end
    chk("idle_dv",  32'(seen_dv), 32'd0);
    chk("idle_cnt", 32'(bus.change_cnt), 32'd0);
    chk("idle_p0",  bus.in_port0, 32'd0);
    chk("idle_p1",  bus.in_port1, 32'd0);

    // Clean step: one edge early nothing shows, then both ports at once.
    bus.sw = 10'b00011_00101;
    step(19);
    chk("step_early_dv", 32'(bus.data_valid), 32'd0);
    chk("step_early_p0", bus.in_port0, 32'd0);
    step(1);
    chk("step_p0",  bus.in_port0, 32'd3);
    chk("step_p1",  bus.in_port1, 32'd5);
    chk("step_dv",  32'(bus.data_valid), 32'd1);
    chk("step_cnt", 32'(bus.change_cnt), 32'd1);
    chk("step_ovr", 32'(bus.overrun), 32'd0);
    rd_pulse();
    chk("rd_clr_dv", 32'(bus.data_valid), 32'd0);
    rd_pulse();
    chk("rd_idle_dv",  32'(bus.data_valid), 32'd0);
    chk("rd_idle_cnt", 32'(bus.change_cnt), 32'd1);

    // Bounce bit 0 every 5 cycles; the last toggle leaves 10'h001 held.
    seen_dv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.sw = (i % 2 == 0) ? 10'h000 : 10'h001;
      for (int j = 0; j < 5; j++) begin
        step(1);
        seen_dv = seen_dv | bus.data_valid;
      end
    end
    chk("bounce_dv",  32'(seen_dv), 32'd0);
    chk("bounce_cnt", 32'(bus.change_cnt), 32'd1);
    step(14);
    chk("bounce_early_dv", 32'(bus.data_valid), 32'd0);
    step(1);
    chk("bounce_dv_set", 32'(bus.data_valid), 32'd1);
    chk("bounce_p0",     bus.in_port0, 32'd0);
    chk("bounce_p1",     bus.in_port1, 32'd1);
    chk("bounce_cnt2",   32'(bus.change_cnt), 32'd2);
    rd_pulse();

    // Glitch for 8 cycles then back to the committed value.
    bus.sw = 10'h2AA;
    step(8);
    bus.sw = 10'h001;
    step(30);
    chk("glitch_cnt", 32'(bus.change_cnt), 32'd2);
    chk("glitch_dv",  32'(bus.data_valid), 32'd0);
    chk("glitch_p0",  bus.in_port0, 32'd0);
    chk("glitch_p1",  bus.in_port1, 32'd1);

    // Two commits without acknowledge.
    bus.sw = 10'h0F0;
    step(20);
    chk("ovr1_cnt", 32'(bus.change_cnt), 32'd3);
    chk("ovr1_ovr", 32'(bus.overrun), 32'd0);
    chk("ovr1_p0",  bus.in_port0, 32'd7);
    chk("ovr1_p1",  bus.in_port1, 32'd16);
    bus.sw = 10'h00F;
    step(20);
    chk("ovr2_cnt", 32'(bus.change_cnt), 32'd4);
    chk("ovr2_dv",  32'(bus.data_valid), 32'd1);
    chk("ovr2_ovr", 32'(bus.overrun), OVR);
    chk("ovr2_p1",  bus.in_port1, 32'd15);

    // Acknowledge lands in the COMMIT cycle of the third change.
    bus.sw = 10'h3E0;
    step(19);
    bus.cpu_rd = 1'b1;
    step(1);
    bus.cpu_rd = 1'b0;
    chk("coinc_dv",  32'(bus.data_valid), 32'd1);
    chk("coinc_ovr", 32'(bus.overrun), OVR);
    chk("coinc_cnt", 32'(bus.change_cnt), 32'd5);
    chk("coinc_p0",  bus.in_port0, 32'd31);
    chk("coinc_p1",  bus.in_port1, 32'd0);
    rd_pulse();
    chk("lone_rd_dv",  32'(bus.data_valid), 32'd0);
    chk("lone_rd_ovr", 32'(bus.overrun), 32'd0);

    // Reset while settling on all-ones, then the held value commits again.
    bus.sw = 10'h3FF;
    step(6);
    reset = 1'b0;
    #1;
    chk("midrst_cnt", 32'(bus.change_cnt), 32'd0);
    chk("midrst_p0",  bus.in_port0, 32'd0);
    chk("midrst_p1",  bus.in_port1, 32'd0);
    chk("midrst_dv",  32'(bus.data_valid), 32'd0);
    step(3);
    reset = 1'b1;
    step(19);
    chk("post_rst_early_dv", 32'(bus.data_valid), 32'd0);
    step(1);
    chk("post_rst_p0",  bus.in_port0, 32'd31);
    chk("post_rst_p1",  bus.in_port1, 32'd31);
    chk("post_rst_dv",  32'(bus.data_valid), 32'd1);
    chk("post_rst_cnt", 32'(bus.change_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/io_input_ctrl.md
Name: io_input_ctrl

Overview:
- Sequences switch input into the single-cycle CPU's two input ports.
- Synchronises and debounces the 10 board switches, then commits stable values into registered in_port0 (SW9..SW5) and in_port1 (SW4..SW0).
- Raises a data_valid flag that the CPU acknowledges with a read strobe.
- Sits between the board switches and sc_computer, replacing the combinational switch-to-port path.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before commit (legal range 2..65535).
- DATA_W, 32, width of each input port.
- CNT_W, 8, width of the commit counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw  input  10  raw switch levels; sw[9:5] is operand 0, sw[4:0] is operand 1.
- cpu_rd  input  1  one-cycle acknowledge from the CPU I/O read decode.
- in_port0  output  DATA_W  zero-extended sw[9:5] from the last commit.
- in_port1  output  DATA_W  zero-extended sw[4:0] from the last commit.
- data_valid  output  1  new committed data not yet acknowledged.
- change_cnt  output  CNT_W  number of commits since reset, wraps.
- overrun  output  1  sticky flag: a commit occurred while data_valid was still 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - in_port0, in_port1, change_cnt = 0; data_valid, overrun = 0.
  - Synchroniser flops = 0, stable register = 0, candidate = 0, debounce counter = 0, state = IDLE.
- Synchroniser: two flops on all 10 bits; sync is the second-flop output.
- FSM states: IDLE, SETTLE, COMMIT.
- IDLE:
  - If sync != stable: candidate <= sync, cnt <= 0, go to SETTLE.
  - Else stay in IDLE.
- SETTLE, evaluated in priority order:
  - sync == stable (bounced back): go to IDLE; no commit.
  - sync != candidate: candidate <= sync, cnt <= 0, stay in SETTLE.
  - cnt == DEBOUNCE_CYCLES-1: go to COMMIT.
  - Otherwise: cnt <= cnt+1.
- COMMIT (exactly one cycle):
  - stable <= candidate.
  - in_port0 <= {0, candidate[9:5]}; in_port1 <= {0, candidate[4:0]}.
  - change_cnt <= change_cnt+1, wrapping 2^CNT_W-1 -> 0.
  - data_valid <= 1.
  - If data_valid was already 1, overrun <= 1.
  - Go to IDLE.
- Latency: after a clean switch change before edge k, outputs update at edge k+DEBOUNCE_CYCLES+3 (k+19 with the default).
- Switch changes arriving during COMMIT are detected in the following IDLE cycle; none are lost.
- cpu_rd:
  - Clears data_valid and overrun on the next edge.
  - cpu_rd while data_valid=0 has no effect.
  - cpu_rd in the same cycle as COMMIT: the set wins, data_valid=1; overrun is evaluated on the pre-edge data_valid.
- in_port0/in_port1 are stable between commits and never show partially debounced values.
- Reset asserted mid-SETTLE or mid-COMMIT: everything returns to reset values immediately.
  - Switches held non-zero through reset release are committed DEBOUNCE_CYCLES+3 edges later.

Optional Feature:
- IO_OVERRUN_EN defined: overrun logic is present as described.
- Not defined: overrun is tied to 0, the overrun register is removed, and data_valid behaviour is unchanged.

Decomposition:
- Package io_ctrl_pkg holds:
  - The state enum (IDLE, SETTLE, COMMIT).
  - SW_W=10 and OPER_W=5.
  - Field positions: OP0_HI=9, OP0_LO=5, OP1_HI=4, OP1_LO=0.
- One sub-module: sw_sync, a parameterised-width 2-flop synchroniser with the same clk/reset.
- FSM, counter and output registers stay in io_input_ctrl.

Test Plan:
- Reset with sw=0, hold 40 cycles -> in_port0=in_port1=0, data_valid=0, change_cnt=0, state never leaves IDLE.
- Step sw to 10'b00011_00101 at edge 0, hold -> at edge 19: in_port0=3, in_port1=5, data_valid=1, change_cnt=1; cpu_rd pulse -> data_valid=0 on the next edge.
- Bounce: toggle sw bit 0 every 5 cycles for 50 cycles, then hold 10'h001 -> no commit during bouncing; exactly one commit DEBOUNCE_CYCLES+3 edges after the last toggle; in_port1=1.
- Glitch back: change sw for 8 cycles, then return to the stable value -> FSM returns to IDLE, change_cnt unchanged, no data_valid.
- Two commits without cpu_rd (IO_OVERRUN_EN defined) -> overrun=1, change_cnt=2; cpu_rd coincident with a third commit -> data_valid stays 1, overrun stays 1; the next lone cpu_rd clears both.
- Assert reset during SETTLE with sw=10'h3FF held -> outputs 0 immediately; after release, commit at edge 19 with in_port0=in_port1=31.
